// File: rtl/ipu_pkg.sv
// Shared definitions for the IPU interrupt requester and the fetch stage.
// Holds the requester state encoding plus constants both sides agree on.
package ipu_pkg;

  typedef enum logic [1:0] {
    IPU_IDLE,
    IPU_REQ,
    IPU_WAIT_ACK,
    IPU_SERVICE
  } ipu_state_e;

  localparam logic [3:0]  RTI_OPCODE = 4'b0011;
  localparam logic [15:0] INT_VEC    = 16'h0005;

  // Lets fetch decode the handler's return instruction the same way everywhere.
  function automatic logic is_rti_opcode(input logic [3:0] opcode);
    return opcode == RTI_OPCODE;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous circular-buffer FIFO for IPU event codes.
// A push that finds the buffer full (with no simultaneous pop) is reported on drop.
module evt_fifo
  import ipu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW      = $clog2(DEPTH);
  localparam int COUNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == COUNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipu_intc.sv
// IPU interrupt requester: queues IPU events, pulses ipu_int toward fetch,
// waits for the acknowledge and holds further requests until the handler returns.
module ipu_intc
  import ipu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4,
  parameter int ACK_TO = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    evt_valid,
  input  logic [CODE_W-1:0]       evt_code,
  input  logic                    int_block,
  input  logic                    int_ack,
  input  logic                    rti,
  input  logic                    ovf_clr,
  output logic                    ipu_int,
  output logic [15:0]             cur_code,
  output logic                    in_service,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    ovf
);

  localparam int TMR_W = $clog2(ACK_TO + 1);

  ipu_state_e        state;
  ipu_state_e        next_state;
  logic [TMR_W-1:0]  tmr;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [CODE_W-1:0] head;

  evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_valid),
    .pop   (fifo_pop),
    .din   (evt_code),
    .dout  (head),
    .empty (fifo_empty),
    .count (pending),
    .drop  (fifo_drop)
  );

  assign in_service = (state == IPU_SERVICE);

  // The request leaves REQ the same cycle it is presented, so ipu_int cannot repeat back to back.
  always_comb begin
    next_state = state;
    ipu_int    = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IPU_IDLE: begin
        if (!fifo_empty) begin
          next_state = IPU_REQ;
        end
      end
      IPU_REQ: begin
        ipu_int = ~int_block;
        if (!int_block) begin
          next_state = IPU_WAIT_ACK;
        end
      end
      IPU_WAIT_ACK: begin
        if (int_ack) begin
          fifo_pop   = 1'b1;
          next_state = IPU_SERVICE;
        end else if (tmr == TMR_W'(ACK_TO - 1)) begin
          next_state = IPU_REQ;
        end
      end
      IPU_SERVICE: begin
        if (rti) begin
          next_state = IPU_IDLE;
        end
      end
      default: next_state = IPU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IPU_IDLE;
      tmr      <= '0;
      cur_code <= 16'h0000;
      ovf      <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IPU_WAIT_ACK) && (next_state == IPU_WAIT_ACK)) begin
        tmr <= tmr + 1'b1;
      end else begin
        tmr <= '0;
      end
      if (fifo_pop) begin
        cur_code <= 16'(head);
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (fifo_drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ipu_intc.sv
// Self-checking bench for ipu_intc: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_ipu_intc;

  localparam int DEPTH  = 4;
  localparam int CODE_W = 4;
  localparam int ACK_TO = 4;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_SVC  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evt_valid = 1'b0;
  logic [CODE_W-1:0] evt_code = '0;
  logic              int_block = 1'b0;
  logic              int_ack = 1'b0;
  logic              rti = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              ipu_int;
  logic [15:0]       cur_code;
  logic              in_service;
  logic [2:0]        pending;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rti_cyc = -100;

  ipu_intc #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W),
    .ACK_TO (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .int_block  (int_block),
    .int_ack    (int_ack),
    .rti        (rti),
    .ovf_clr    (ovf_clr),
    .ipu_int    (ipu_int),
    .cur_code   (cur_code),
    .in_service (in_service),
    .pending    (pending),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to the next cycle and drive that cycle's inputs.
  task automatic applyStimulus(input logic v, input logic [CODE_W-1:0] c, input logic blk,
                               input logic ack, input logic r, input logic clr);
    @(posedge clk);
    #1;
    cyc++;
    evt_valid = v;
    evt_code  = c;
    int_block = blk;
    int_ack   = ack;
    rti       = r;
    ovf_clr   = clr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Wait for a request, acknowledge it, check the delivered code, then return.
  task automatic serveOne(input logic [CODE_W-1:0] expected, input bit check_gap);
    int  waited;
    bit  found;
    waited = 0;
    found  = 0;
    while (!found && waited < 40) begin
      idle();
      waited++;
      if (ipu_int === 1'b1) found = 1;
    end
    checkOutput("ipu_int_seen", {31'b0, found}, 32'd1);
    if (found) begin
      if (check_gap) checkOutput("rti_to_int_gap_ge2", {31'b0, (cyc - last_rti_cyc) >= 2}, 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("svc_in_service", {31'b0, in_service}, 32'd1);
      checkOutput("svc_cur_code", {16'b0, cur_code}, {28'b0, expected});
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      last_rti_cyc = cyc;
      idle();
      checkOutput("after_rti_in_service", {31'b0, in_service}, 32'd0);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mq[$];
  int          m_phase = P_IDLE;
  int          m_wait = 0;
  logic [15:0] m_cur = 16'h0;
  logic        m_ovf = 1'b0;
  bit          m_valid = 0;
  logic        prev_int = 1'b0;
  int          old_size;
  int          popped;
  bit          do_pop;
  bit          dropped;

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("m_ipu_int", {31'b0, ipu_int}, {31'b0, (m_phase == P_REQ) && !int_block});
      checkOutput("m_in_service", {31'b0, in_service}, {31'b0, m_phase == P_SVC});
      checkOutput("m_cur_code", {16'b0, cur_code}, {16'b0, m_cur});
      checkOutput("m_pending", {29'b0, pending}, mq.size());
      checkOutput("m_ovf", {31'b0, ovf}, {31'b0, m_ovf});
      if (prev_int === 1'b1) checkOutput("ipu_int_back_to_back", {31'b0, ipu_int}, 32'd0);
    end
    prev_int = ipu_int;
    if (rst) begin
      mq.delete();
      m_phase = P_IDLE;
      m_wait  = 0;
      m_cur   = 16'h0;
      m_ovf   = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      old_size = mq.size();
      do_pop   = (m_phase == P_WAIT) && int_ack;
      dropped  = 0;
      popped   = 0;
      if (do_pop && mq.size() > 0) popped = mq.pop_front();
      if (evt_valid) begin
        if (mq.size() < DEPTH) mq.push_back(int'(evt_code));
        else dropped = 1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      case (m_phase)
        P_IDLE: if (old_size != 0) m_phase = P_REQ;
        P_REQ: if (!int_block) begin m_phase = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          if (int_ack) begin
            m_phase = P_SVC;
            m_cur   = 16'(popped);
          end else begin
            m_wait++;
            if (m_wait == ACK_TO) m_phase = P_REQ;
          end
        end
        default: if (rti) m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  int   n;
  bit   seen;
  logic last_int;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_pending", {29'b0, pending}, 32'd0);
    checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);
    checkOutput("reset_in_service", {31'b0, in_service}, 32'd0);
    checkOutput("reset_cur_code", {16'b0, cur_code}, 32'd0);
    checkOutput("reset_ipu_int", {31'b0, ipu_int}, 32'd0);

    // Single event: push 0xA in cycle 0.
    evt_valid = 1'b1; evt_code = 4'hA;
    idle();
    checkOutput("t1_c1_pending", {29'b0, pending}, 32'd1);
    checkOutput("t1_c1_ipu_int", {31'b0, ipu_int}, 32'd0);
    idle();
    checkOutput("t1_c2_ipu_int", {31'b0, ipu_int}, 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_c3_ipu_int", {31'b0, ipu_int}, 32'd0);
    idle();
    checkOutput("t1_c4_cur_code", {16'b0, cur_code}, 32'h000A);
    checkOutput("t1_c4_in_service", {31'b0, in_service}, 32'd1);
    checkOutput("t1_c4_pending", {29'b0, pending}, 32'd0);
    repeat (3) idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    checkOutput("t1_c9_in_service", {31'b0, in_service}, 32'd0);

    // Blocking in cycles 2..5.
    evt_valid = 1'b1; evt_code = 4'h5;
    idle();
    for (int c = 2; c <= 5; c++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_blocked_ipu_int", {31'b0, ipu_int}, 32'd0);
    end
    idle();
    checkOutput("t2_c6_ipu_int", {31'b0, ipu_int}, 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    checkOutput("t2_c8_in_service", {31'b0, in_service}, 32'd1);
    checkOutput("t2_c8_cur_code", {16'b0, cur_code}, 32'h0005);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    last_rti_cyc = cyc;
    idle();

    // Overflow: five pushes into a four-entry queue while fetch is blocked.
    evt_valid = 1'b1; evt_code = 4'h1; int_block = 1'b1;
    for (int k = 2; k <= 5; k++) applyStimulus(1'b1, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_pending_full", {29'b0, pending}, 32'd4);
    checkOutput("t3_ovf_set", {31'b0, ovf}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_ovf_cleared", {31'b0, ovf}, 32'd0);
    for (int k = 1; k <= 4; k++) serveOne(4'(k), 1'b0);
    checkOutput("t3_drained", {29'b0, pending}, 32'd0);
    seen = 0;
    repeat (8) begin
      idle();
      if (ipu_int === 1'b1) seen = 1;
    end
    checkOutput("t3_fifth_not_delivered", {31'b0, seen}, 32'd0);

    // Ack timeout: re-request ACK_TO+1 cycles after the first pulse.
    evt_valid = 1'b1; evt_code = 4'h7;
    idle();
    idle();
    checkOutput("t4_first_pulse", {31'b0, ipu_int}, 32'd1);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      idle();
      n++;
      if (ipu_int === 1'b1) seen = 1;
    end
    checkOutput("t4_repulse_distance", n, ACK_TO + 1);
    checkOutput("t4_pending_kept", {29'b0, pending}, 32'd1);
    serveOne(4'h7, 1'b0);

    // Ordering 1,2,3 with gaps after each return.
    evt_valid = 1'b1; evt_code = 4'h1; int_block = 1'b1;
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    serveOne(4'h1, 1'b0);
    serveOne(4'h2, 1'b1);
    serveOne(4'h3, 1'b1);

    // Push and pop together while full.
    evt_valid = 1'b1; evt_code = 4'h8; int_block = 1'b1;
    for (int k = 9; k <= 11; k++) applyStimulus(1'b1, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      idle();
      n++;
      if (ipu_int === 1'b1) seen = 1;
    end
    checkOutput("t5_full_pulse_seen", {31'b0, seen}, 32'd1);
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    checkOutput("t5_full_pushpop_pending", {29'b0, pending}, 32'd4);
    checkOutput("t5_full_pushpop_ovf", {31'b0, ovf}, 32'd0);
    checkOutput("t5_full_pushpop_code", {16'b0, cur_code}, 32'h0008);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    last_rti_cyc = cyc;
    idle();
    serveOne(4'h9, 1'b1);
    serveOne(4'hA, 1'b1);
    serveOne(4'hB, 1'b1);
    serveOne(4'hC, 1'b1);

    // Reset while in service with two events still queued.
    evt_valid = 1'b1; evt_code = 4'hD; int_block = 1'b1;
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      idle();
      n++;
      if (ipu_int === 1'b1) seen = 1;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    checkOutput("t6_in_service_before_rst", {31'b0, in_service}, 32'd1);
    checkOutput("t6_pending_before_rst", {29'b0, pending}, 32'd2);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_in_service", {31'b0, in_service}, 32'd0);
    checkOutput("t6_rst_pending", {29'b0, pending}, 32'd0);
    checkOutput("t6_rst_cur_code", {16'b0, cur_code}, 32'd0);
    seen = 0;
    repeat (10) begin
      idle();
      if (ipu_int === 1'b1) seen = 1;
    end
    checkOutput("t6_no_int_after_rst", {31'b0, seen}, 32'd0);

    // Randomized traffic, checked by the model process every cycle.
    last_int = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 4'($urandom),
                    $urandom_range(0, 3) == 0,
                    (last_int && $urandom_range(0, 3) != 0) || ($urandom_range(0, 15) == 0),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      last_int = ipu_int;
    end
    rst = 1'b0;
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
